// File: rtl/babbage_pkg.sv
// Shared constants and types for the Babbage difference-engine family.
package babbage_pkg;
    localparam int DEGREE    = 5;
    localparam int NSAMP     = DEGREE + 2;
    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;
endpackage

// File: rtl/babbage_diff_pass.sv
// One forward-difference pass: entries j >= k become s[j] - s[j-1], computed from the pre-pass values.
module babbage_diff_pass
    import babbage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]             k,
    input  logic [NSAMP*WIDTH-1:0] s_in,
    output logic [NSAMP*WIDTH-1:0] s_out
);

    always_comb begin
        // NOTE: assigning a default first keeps this block latch-free.
        s_out = s_in;
        for (int j = 1; j < NSAMP; j++) begin
            if (3'(j) >= k) begin
                s_out[j*WIDTH +: WIDTH] = s_in[j*WIDTH +: WIDTH] - s_in[(j-1)*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/babbage_diff_extract.sv
// Recovers the difference-engine seed table (delta^0..delta^5 at n=0) from seven samples u(0)..u(6).
module babbage_diff_extract
    import babbage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sample,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] d4,
    output logic [WIDTH-1:0] d5,
    output logic             deg_err,
    output logic             done_tick
);

    state_t                        state;
    logic [NSAMP-1:0][WIDTH-1:0]   s;
    logic [NSAMP*WIDTH-1:0]        s_next;
    logic [2:0]                    cnt;
    logic [2:0]                    k;

    babbage_diff_pass #(.WIDTH(WIDTH)) u_pass (
        .k     (k),
        .s_in  (s),
        .s_out (s_next)
    );

    // NOTE: all state here is sequential, so every assignment is non-blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            in_ready  <= 1'b0;
            done_tick <= 1'b0;
            deg_err   <= 1'b0;
            d0        <= '0;
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            d4        <= '0;
            d5        <= '0;
            s         <= '0;
            cnt       <= '0;
            k         <= '0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        ready    <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        s[cnt] <= in_sample;
                        cnt    <= cnt + 3'd1;
                        if (cnt == 3'(NSAMP - 1)) begin
                            state    <= CALC;
                            k        <= 3'd1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    s <= s_next;
                    if (k == 3'(NSAMP - 1)) begin
                        state <= DONE;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                DONE: begin
                    // After pass 6, s[j] holds delta^j u(0); a nonzero delta^6 means degree > 5.
                    d0        <= s[0];
                    d1        <= s[1];
                    d2        <= s[2];
                    d3        <= s[3];
                    d4        <= s[4];
                    d5        <= s[5];
                    deg_err   <= (s[NSAMP-1] != '0);
                    done_tick <= 1'b1;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    ready    <= 1'b1;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_babbage_diff_extract.sv
// Directed bench for babbage_diff_extract: hand-computed difference tables and control corner cases.
module tb_babbage_diff_extract;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ready;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_sample;
    logic [31:0] d0, d1, d2, d3, d4, d5;
    logic        deg_err;
    logic        done_tick;

    int tests = 0;
    int fails = 0;

    babbage_diff_extract #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ready     (ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .d4        (d4),
        .d5        (d5),
        .deg_err   (deg_err),
        .done_tick (done_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Pulses start, feeds seven samples and returns cycles from the last accept to done_tick.
    task automatic run(input int v[7], input bit noisy, output int lat);
        int  i     = 0;
        int  guard = 0;
        bit  acc;
        start = 1'b1;
        step();
        start = 1'b0;
        while (i < 7 && guard < 200) begin
            in_valid  = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            in_sample = v[i];
            acc       = in_valid && in_ready;
            step();
            guard++;
            if (acc) i++;
        end
        check("samples_accepted", i, 7);
        lat = 0;
        while (!done_tick && lat < 20) begin
            start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            lat++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input int e[6], input logic err);
        check({tag, "_d0"}, d0, e[0]);
        check({tag, "_d1"}, d1, e[1]);
        check({tag, "_d2"}, d2, e[2]);
        check({tag, "_d3"}, d3, e[3]);
        check({tag, "_d4"}, d4, e[4]);
        check({tag, "_d5"}, d5, e[5]);
        check({tag, "_deg_err"}, 32'(deg_err), 32'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int quint_s[7]  = '{0, 1, 32, 243, 1024, 3125, 7776};
        int quint_e[6]  = '{0, 1, 30, 150, 240, 120};
        int const_s[7]  = '{219, 219, 219, 219, 219, 219, 219};
        int const_e[6]  = '{219, 0, 0, 0, 0, 0};
        int lin_s[7]    = '{219, 248, 277, 306, 335, 364, 393};
        int lin_e[6]    = '{219, 29, 0, 0, 0, 0};
        int sext_s[7]   = '{0, 1, 64, 729, 4096, 15625, 46656};
        int sext_e[6]   = '{0, 1, 62, 540, 1560, 1800};
        int eng_s[7]    = '{219, 261, 345, 423, 255, -711, -3459};
        int eng_e[6]    = '{219, 42, 42, -48, -192, -120};
        int zero_e[6]   = '{0, 0, 0, 0, 0, 0};

        reset     = 1'b1;
        start     = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        step();
        step();
        start = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_done_tick", 32'(done_tick), 32'd0);
        check_out("rst", zero_e, 1'b0);
        reset = 1'b0;
        step();

        // u(n) = n^5
        run(quint_s, 1'b0, lat);
        check("quint_latency", lat, 7);
        check_out("quint", quint_e, 1'b0);
        check("quint_ready", 32'(ready), 32'd1);
        step();
        check("quint_tick_drop", 32'(done_tick), 32'd0);

        run(const_s, 1'b0, lat);
        check_out("const", const_e, 1'b0);
        run(lin_s, 1'b0, lat);
        check_out("linear", lin_e, 1'b0);

        // u(n) = n^6 has delta^6 = 720
        run(sext_s, 1'b0, lat);
        check_out("sextic", sext_e, 1'b1);

        // -n^5 + 2n^4 + 5n^3 + 7n^2 + 29n + 219
        run(eng_s, 1'b0, lat);
        check_out("engine", eng_e, 1'b0);

        // Backpressure with spurious start pulses
        run(quint_s, 1'b1, lat);
        check("noisy_latency", lat, 7);
        check_out("noisy", quint_e, 1'b0);

        // in_valid while IDLE must not start or alter anything
        step();
        in_valid  = 1'b1;
        in_sample = 32'd999;
        for (int c = 0; c < 4; c++) step();
        in_valid = 1'b0;
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_tick", 32'(done_tick), 32'd0);
        check_out("idle", quint_e, 1'b0);

        // Reset during CALC pass 3
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid  = 1'b1;
            in_sample = eng_s[i];
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check_out("midrst", zero_e, 1'b0);
        begin
            int ticks = 0;
            for (int c = 0; c < 12; c++) begin
                if (done_tick) ticks++;
                step();
            end
            check("midrst_no_tick", ticks, 0);
        end

        run(quint_s, 1'b0, lat);
        check("post_latency", lat, 7);
        check_out("post", quint_e, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/babbage_diff_extract.md
Name: babbage_diff_extract

Overview:
Inverse of the Babbage difference engine. It accepts seven consecutive polynomial samples u(0)..u(6) and produces the initial forward-difference vector Δ^0..Δ^5 of u at n=0, which is the engine's seed table. It also flags a nonzero Δ^6, meaning the samples do not come from a polynomial of degree ≤5. It sits upstream of the engine and is used to seed the engine from measured or reference samples, and to cross-check the engine's output stream.

Parameters:
WIDTH, 32, bit width of samples, working registers and outputs (signed two's complement)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; accepted only when ready=1
ready  output  1  high in IDLE only
in_valid  input  1  sample strobe
in_ready  output  1  high in LOAD only
in_sample  input  WIDTH  signed sample u(k), presented in order k=0..6
d0..d5  output  WIDTH each  signed Δ^0..Δ^5 u(0), registered, held until the next start
deg_err  output  1  registered; 1 when Δ^6 u(0) ≠ 0, held with d0..d5
done_tick  output  1  one-cycle pulse when d0..d5 and deg_err become valid

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and reset.
- States: IDLE, LOAD, CALC, DONE.
- Reset values: state=IDLE, ready=1, in_ready=0, done_tick=0, deg_err=0, d0..d5=0; working registers s[0..6]=0, sample counter=0, pass counter=0.
- IDLE: ready=1. On start=1, go to LOAD and clear the sample counter. Outputs keep their previous values.
- LOAD: in_ready=1. A sample is accepted when in_valid && in_ready. On acceptance, s[cnt] <= in_sample and cnt increments. in_valid=0 stalls with no state change. Accepting the 7th sample (cnt=6) goes to CALC with pass k=1 and drops in_ready in the next cycle.
- CALC: one pass per cycle, k=1..6. For all j≥k in parallel, s[j] <= s[j] − s[j−1], using pre-pass values. s[j] for j<k is unchanged. After pass 6, s[k]=Δ^k u(0), then go to DONE.
- DONE: lasts one cycle. Register d0..d5 <= s[0..5], deg_err <= (s[6]≠0), done_tick=1. Then return to IDLE.
- Latency: the 7th sample accept edge is cycle 0. The pass k=1 result is registered at the cycle-1 edge and pass 6 at the cycle-6 edge. done_tick is high during cycle 7, and the outputs are valid from cycle 7 onward.
- Start rules: start outside IDLE is ignored. start together with reset: reset wins.
- Arithmetic: all subtraction is WIDTH-bit modular two's complement, with no saturation and no overflow flag. Results are exact mod 2^WIDTH. Sample bounds are the source's responsibility, consistent with the engine's no-overflow coefficient widths.
- Reset mid-operation (LOAD or CALC): return to IDLE next edge. Partial samples are discarded, no done_tick is issued, and outputs are cleared to 0.
- in_valid outside LOAD is ignored.

Decomposition:
- Shared package babbage_pkg holds:
  - DEGREE=5
  - NSAMP=DEGREE+2=7
  - the state enum {IDLE, LOAD, CALC, DONE}
  - the default WIDTH=32, shared with babbage_top.
- Sub-module babbage_diff_pass: combinational, one difference pass over s[0..6] with pass index k. It keeps the top-level FSM small and is reusable for an inverse check inside babbage_top's bench. Everything else stays in one module.

Test Plan:
- u(n)=n^5, samples 0,1,32,243,1024,3125,7776 → d0..d5 = 0,1,30,150,240,120; deg_err=0; done_tick exactly 7 cycles after the last accept.
- Constant 219 ×7 → d0=219, d1..d5=0, deg_err=0. Then linear 29n+219 (219,248,277,306,335,364,393) → d0=219, d1=29, rest 0.
- u(n)=n^6, samples 0,1,64,729,4096,15625,46656 → deg_err=1, d5=1800, d0=0.
- Engine round-trip: a=−1, b=2, c=5, d=7, f=29, g=219, feed u(0..6) from the multiplication method → d0..d5 match the engine's initial difference registers for those coefficients; deg_err=0.
- Backpressure and spurious inputs: in_valid toggled 1/0 randomly during LOAD, with start pulsed during LOAD and CALC → same results as the first test; extra starts are ignored; in_valid while IDLE changes nothing.
- Sync reset asserted during CALC pass 3 → IDLE next edge, no done_tick, d0..d5=0, ready=1. A following clean run of the first test passes.
